signed_stream_accumulator: RTL and testbench



---
 rtl/signed_stream_accumulator.sv | 130 +++++++++++++
 tb/tb_signed_stream_accumulator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/signed_stream_accumulator.sv
// Signed packet accumulator with valid/ready in, held result out.
// Define SIGNED_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module signed_stream_accumulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam int unsigned EXT_W = OUT_W - WIDTH;
`ifdef SIGNED_ACC_SATURATE_EN
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [OUT_W-1:0]   ext_c, sum_c, nxt_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               step_ovf_c;
    logic               xfer_c;

    // Datapath: sign-extend, add, detect signed overflow, optionally clamp
    always_comb begin
        ext_c      = {{EXT_W{in_data[WIDTH-1]}}, in_data};
        sum_c      = acc_q + ext_c;
        step_ovf_c = (acc_q[OUT_W-1] == ext_c[OUT_W-1]) && (sum_c[OUT_W-1] != acc_q[OUT_W-1]);
`ifdef SIGNED_ACC_SATURATE_EN
        if (step_ovf_c) begin
            nxt_c = acc_q[OUT_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            nxt_c = sum_c;
        end
`else
        nxt_c = sum_c;
`endif
        cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        xfer_c    = in_valid & in_ready_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        unique case (state_q)
            ST_ACC: begin
                if (xfer_c) begin
                    if (in_last) begin
                        out_sum_d = nxt_c;
                        out_cnt_d = cnt_inc_c;
                        out_ovf_d = ovf_q | step_ovf_c;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = ST_HOLD;
                    end else begin
                        acc_d = nxt_c;
                        cnt_d = cnt_inc_c;
                        ovf_d = ovf_q | step_ovf_c;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_signed_stream_accumulator.sv
// Directed bench for signed_stream_accumulator: beat table plus hand-written corner sequences.
module tb_signed_stream_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_last, out_ready;
    logic signed [7:0]  in_data;
    logic               in_ready, out_valid, out_ovf;
    logic signed [11:0] out_sum;
    logic [7:0]         out_cnt;

    // Second instance with a 2-bit counter for saturation
    logic               c_in_valid, c_in_last, c_in_ready, c_out_valid, c_out_ovf;
    logic signed [7:0]  c_in_data;
    logic signed [11:0] c_out_sum;
    logic [1:0]         c_out_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_stream_accumulator #(.WIDTH(8), .OUT_W(12), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    signed_stream_accumulator #(.WIDTH(8), .OUT_W(12), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_sum(c_out_sum), .out_cnt(c_out_cnt), .out_ovf(c_out_ovf)
    );

    typedef struct {
        logic signed [7:0]  d;
        logic               last;
        logic signed [11:0] exp_sum;
        int                 exp_cnt;
        logic               exp_ovf;
    } beat_t;

    beat_t vec[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one beat and wait (bounded) for it to be accepted
    task automatic send_beat(input logic signed [7:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after the last beat: check result and drain it
    task automatic check_result(input string tag, input int s, input int c, input logic o);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_in_ready_low"}, int'(in_ready), 0);
        chk({tag, "_sum"}, int'(out_sum), s);
        chk({tag, "_cnt"}, int'(out_cnt), c);
        chk({tag, "_ovf"}, int'(out_ovf), int'(o));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
        chk({tag, "_valid_drop"}, int'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    task automatic add_beat(input logic signed [7:0] d, input logic last,
                            input int s, input int c, input logic o);
        beat_t b;
        b.d = d; b.last = last; b.exp_sum = 12'(s); b.exp_cnt = c; b.exp_ovf = o;
        vec.push_back(b);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0;

        add_beat(8'sd5, 1'b0, 0, 0, 1'b0);
        add_beat(-8'sd3, 1'b0, 0, 0, 1'b0);
        add_beat(8'sd100, 1'b1, 102, 3, 1'b0);
        add_beat(-8'sd128, 1'b1, -128, 1, 1'b0);
        add_beat(-8'sd100, 1'b0, 0, 0, 1'b0);
        add_beat(-8'sd100, 1'b0, 0, 0, 1'b0);
        add_beat(-8'sd100, 1'b1, -300, 3, 1'b0);
        for (int i = 0; i < 16; i++) add_beat(8'sd127, 1'b0, 0, 0, 1'b0);
`ifdef SIGNED_ACC_SATURATE_EN
        add_beat(8'sd127, 1'b1, 2047, 17, 1'b1);
`else
        add_beat(8'sd127, 1'b1, -1937, 17, 1'b1);
`endif
        // Sticky flag cleared for the following packet
        add_beat(8'sd1, 1'b1, 1, 1, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);

        foreach (vec[i]) begin
            send_beat(vec[i].d, vec[i].last);
            if (vec[i].last) check_result($sformatf("vec%0d", i), int'(vec[i].exp_sum),
                                          vec[i].exp_cnt, vec[i].exp_ovf);
        end

        // Backpressure: result held, pending beat not consumed during HOLD
        send_beat(8'sd1, 1'b0);
        send_beat(8'sd2, 1'b1);
        in_valid = 1'b1; in_data = 8'sd9; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), int'(out_valid), 1);
            chk($sformatf("bp_sum%0d", k), int'(out_sum), 3);
            chk($sformatf("bp_in_ready%0d", k), int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check_result("bp_next", 9, 1, 1'b0);

        // Reset mid-packet discards the partial sum
        send_beat(8'sd50, 1'b0);
        send_beat(8'sd50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        send_beat(8'sd7, 1'b1);
        check_result("mid_rst", 7, 1, 1'b0);

        // Counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 6; k++) begin
            c_in_valid = 1'b1; c_in_data = 8'sd0; c_in_last = (k == 5);
            chk($sformatf("c2_ready%0d", k), int'(c_in_ready), 1);
            @(posedge clk);
            @(negedge clk);
        end
        c_in_valid = 1'b0;
        chk("c2_valid", int'(c_out_valid), 1);
        chk("c2_cnt", int'(c_out_cnt), 3);
        chk("c2_sum", int'(c_out_sum), 0);
        chk("c2_ovf", int'(c_out_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
